// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg
//   Shared definitions for the cache-line transfer engine: the default
//   geometry (3-bit word address, 32-bit words, 2 words per line), the
//   derived line constants, and the engine state encoding.
package mem_xfer_pkg;

    localparam int AWIDTH_DEF = 3;
    localparam int DWIDTH_DEF = 32;
    localparam int OFFW_DEF   = 1;

    // Words per line and line-address width for the default geometry.
    localparam int LINE_WORDS = 1 << OFFW_DEF;
    localparam int LAW        = AWIDTH_DEF - OFFW_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_LAST = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_line_xfer_if.sv
// mem_line_xfer_if
//   Bundles the request/response handshake between the cache controller and
//   the transfer engine, plus the data-RAM access signals.
//
//   Handshake: a request is taken on a rising edge where req_valid and
//   req_ready are both 1; req_write, req_line_addr and req_wdata are sampled
//   on that edge only.  req_valid seen while req_ready is 0 is ignored, not
//   queued.  resp_valid is a single-cycle completion pulse; resp_rdata is
//   meaningful while resp_valid is 1 after a fill and holds until the next
//   fill completes.
//
//   Modports:
//     slave  - the engine (mem_line_xfer)
//     master - the controller plus the RAM (drives requests and mem_dout)
interface mem_line_xfer_if
    import mem_xfer_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int OFFW   = OFFW_DEF
) ();

    localparam int N_WORDS = 1 << OFFW;
    localparam int LINE_AW = AWIDTH - OFFW;

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [LINE_AW-1:0]           req_line_addr;
    logic [DWIDTH*N_WORDS-1:0]    req_wdata;
    logic                         resp_valid;
    logic [DWIDTH*N_WORDS-1:0]    resp_rdata;
    logic [AWIDTH-1:0]            mem_addr;
    logic [DWIDTH-1:0]            mem_din;
    logic                         mem_we;
    logic [DWIDTH-1:0]            mem_dout;

    modport slave (
        input  req_valid, req_write, req_line_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_we
    );

    modport master (
        output req_valid, req_write, req_line_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/mem_line_buf.sv
// mem_line_buf
//   One cache line of storage (N_WORDS x DWIDTH).
//   Ports:
//     clock, reset_n - clock and asynchronous active-low clear
//     load_en/line_in - load the whole line at once (writeback source)
//     wr_en/wr_idx/wr_data - write one word (fill capture)
//     rd_idx/rd_data - read one stored word
//     line_nxt - the line as it will be after this edge's updates, so a
//                caller can register the complete line on the same edge
//                the last word is captured
module mem_line_buf
    import mem_xfer_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int OFFW   = OFFW_DEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [DWIDTH*(1<<OFFW)-1:0]   line_in,
    input  logic                          wr_en,
    input  logic [OFFW-1:0]               wr_idx,
    input  logic [DWIDTH-1:0]             wr_data,
    input  logic [OFFW-1:0]               rd_idx,
    output logic [DWIDTH-1:0]             rd_data,
    output logic [DWIDTH*(1<<OFFW)-1:0]   line_nxt
);

    localparam int N_WORDS = 1 << OFFW;

    logic [DWIDTH-1:0] words_q [N_WORDS];
    logic [DWIDTH-1:0] words_d [N_WORDS];

    always_comb begin
        words_d = words_q;
        if (load_en) begin
            for (int i = 0; i < N_WORDS; i++) begin
                words_d[i] = line_in[i*DWIDTH +: DWIDTH];
            end
        end
        if (wr_en) begin
            words_d[wr_idx] = wr_data;
        end
    end

    always_comb begin
        line_nxt = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            line_nxt[i*DWIDTH +: DWIDTH] = words_d[i];
        end
    end

    assign rd_data = words_q[rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/mem_line_xfer.sv
// mem_line_xfer
//   Initiator engine that moves whole cache lines to/from a single-port
//   synchronous-read RAM (read data appears the cycle after the address).
//   A fill issues LINE_WORDS ascending read addresses and returns the line
//   with a one-cycle resp_valid; a writeback issues LINE_WORDS ascending
//   writes and then pulses resp_valid.  All outputs are registered.
//   Ports:
//     clock, reset_n - clock and asynchronous active-low reset
//     bus            - request/response handshake and RAM signals (slave)
//     dbg_state      - current engine state
module mem_line_xfer
    import mem_xfer_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int OFFW   = OFFW_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    mem_line_xfer_if.slave  bus,
    output state_t          dbg_state
);

    localparam int N_WORDS = 1 << OFFW;
    localparam int LINE_AW = AWIDTH - OFFW;
    localparam int CW      = OFFW + 1;
    localparam int LINE_DW = DWIDTH * N_WORDS;

    state_t               state_q,      state_d;
    logic [CW-1:0]        cnt_q,        cnt_d;
    logic [LINE_AW-1:0]   line_q,       line_d;
    logic                 req_ready_q,  req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [LINE_DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic [AWIDTH-1:0]    mem_addr_q,   mem_addr_d;
    logic [DWIDTH-1:0]    mem_din_q,    mem_din_d;
    logic                 mem_we_q,     mem_we_d;

    logic                 buf_load;
    logic                 buf_wr_en;
    logic [OFFW-1:0]      buf_wr_idx;
    logic [OFFW-1:0]      buf_rd_idx;
    logic [DWIDTH-1:0]    buf_rd_data;
    logic [LINE_DW-1:0]   buf_line_nxt;

    // Offset of the word after the one currently presented.
    logic [OFFW-1:0]      nxt_off;
    logic                 last_word;

    assign nxt_off   = cnt_q[OFFW-1:0] + OFFW'(1);
    assign last_word = (cnt_q == CW'(N_WORDS - 1));

    mem_line_buf #(
        .DWIDTH (DWIDTH),
        .OFFW   (OFFW)
    ) u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_en  (buf_load),
        .line_in  (bus.req_wdata),
        .wr_en    (buf_wr_en),
        .wr_idx   (buf_wr_idx),
        .wr_data  (bus.mem_dout),
        .rd_idx   (buf_rd_idx),
        .rd_data  (buf_rd_data),
        .line_nxt (buf_line_nxt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        buf_load     = 1'b0;
        buf_wr_en    = 1'b0;
        // RAM data lags the address by one cycle, so the word arriving now
        // belongs to the offset presented last cycle.
        buf_wr_idx   = cnt_q[OFFW-1:0] - OFFW'(1);
        buf_rd_idx   = nxt_off;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    line_d      = bus.req_line_addr;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    mem_addr_d  = {bus.req_line_addr, OFFW'(0)};
                    if (bus.req_write) begin
                        buf_load  = 1'b1;
                        mem_din_d = bus.req_wdata[DWIDTH-1:0];
                        mem_we_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        state_d   = ST_RD;
                    end
                end
            end

            ST_RD: begin
                buf_wr_en = (cnt_q != '0);
                cnt_d     = cnt_q + CW'(1);
                if (last_word) begin
                    state_d = ST_RD_LAST;
                end else begin
                    mem_addr_d = {line_q, nxt_off};
                end
            end

            ST_RD_LAST: begin
                // Final word lands in the buffer and the response register
                // on the same edge.
                buf_wr_en    = 1'b1;
                resp_rdata_d = buf_line_nxt;
                resp_valid_d = 1'b1;
                state_d      = ST_DONE;
            end

            ST_WR: begin
                if (last_word) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    mem_addr_d = {line_q, nxt_off};
                    mem_din_d  = buf_rd_data;
                    mem_we_d   = 1'b1;
                end
            end

            ST_DONE: begin
                cnt_d       = '0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_we     = mem_we_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer
//   Directed plus randomized bench for mem_line_xfer with a behavioural RAM
//   and a word-array reference of the RAM contents.
module tb_mem_line_xfer;
    import mem_xfer_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    int checks   = 0;
    int errors   = 0;
    int resp_cnt = 0;

    logic [31:0] ram     [8];
    logic [31:0] ref_mem [8];
    bit          ram_init_done = 1'b0;

    logic [63:0] last_fill;
    logic [31:0] exp_din;

    mem_line_xfer_if #(.AWIDTH(3), .DWIDTH(32), .OFFW(1)) bus ();

    mem_line_xfer #(.AWIDTH(3), .DWIDTH(32), .OFFW(1)) dut (
        .clock     (clk),
        .reset_n   (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model: registered read address, write on edge ----
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 8; i++) ram[i] <= 32'h1000_0000 + i;
            ram_init_done <= 1'b1;
            bus.mem_dout  <= '0;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (bus.resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_line(input int line);
        return {ref_mem[2*line+1], ref_mem[2*line]};
    endfunction

    // ---------------- driver: one complete transfer with per-cycle checks ---
    task automatic xfer(input bit wr, input int line, input logic [63:0] wd);
        logic [63:0] exp_line;
        @(negedge clk);
        chk("ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid     = 1'b1;
        bus.req_write     = wr;
        bus.req_line_addr = 2'(line);
        bus.req_wdata     = wd;
        @(posedge clk);
        #1;
        bus.req_valid     = 1'b0;
        bus.req_write     = ~wr;
        bus.req_line_addr = 2'($urandom_range(0, 3));
        bus.req_wdata     = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("addr",       64'(bus.mem_addr),   64'(line * 2 + k));
            chk("we",         64'(bus.mem_we),     64'(wr));
            chk("ready_busy", 64'(bus.req_ready),  64'd0);
            chk("resp_early", 64'(bus.resp_valid), 64'd0);
            chk("rdata_hold", bus.resp_rdata,      last_fill);
            if (wr) chk("din", 64'(bus.mem_din), 64'(wd[k*32 +: 32]));
            else    chk("din_hold", 64'(bus.mem_din), 64'(exp_din));
        end
        if (wr) begin
            exp_din             = wd[63:32];
            ref_mem[2*line]     = wd[31:0];
            ref_mem[2*line + 1] = wd[63:32];
        end else begin
            @(negedge clk);
            chk("rd_gap_resp", 64'(bus.resp_valid), 64'd0);
            chk("rd_gap_we",   64'(bus.mem_we),     64'd0);
            chk("rd_gap_addr", 64'(bus.mem_addr),   64'(line * 2 + 1));
        end
        @(negedge clk);
        chk("resp",      64'(bus.resp_valid), 64'd1);
        chk("done_we",   64'(bus.mem_we),     64'd0);
        chk("done_addr", 64'(bus.mem_addr),   64'(line * 2 + 1));
        chk("done_din",  64'(bus.mem_din),    64'(exp_din));
        chk("done_rdy",  64'(bus.req_ready),  64'd0);
        if (!wr) begin
            exp_line  = ref_line(line);
            chk("rdata", bus.resp_rdata, exp_line);
            last_fill = exp_line;
        end else begin
            chk("wb_rdata_hold", bus.resp_rdata, last_fill);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] wd;
        logic [31:0] old2, old3;
        int          rc0;

        for (int i = 0; i < 8; i++) ref_mem[i] = 32'h1000_0000 + i;
        last_fill         = '0;
        exp_din           = '0;
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_line_addr = '0;
        bus.req_wdata     = '0;

        // reset state
        #12;
        chk("rst_ready", 64'(bus.req_ready),  64'd1);
        chk("rst_resp",  64'(bus.resp_valid), 64'd0);
        chk("rst_rdata", bus.resp_rdata,      64'd0);
        chk("rst_addr",  64'(bus.mem_addr),   64'd0);
        chk("rst_din",   64'(bus.mem_din),    64'd0);
        chk("rst_we",    64'(bus.mem_we),     64'd0);
        chk("rst_state", 64'(dbg_state),      64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // fill line 2, writeback line 3 and read it back
        xfer(1'b0, 2, '0);
        xfer(1'b1, 3, 64'hBBBB_0001_AAAA_0000);
        xfer(1'b0, 3, '0);

        // req_valid held high through a fill: second request only after resp
        @(negedge clk);
        chk("held_ready0", 64'(bus.req_ready), 64'd1);
        rc0 = resp_cnt;
        bus.req_valid     = 1'b1;
        bus.req_write     = 1'b0;
        bus.req_line_addr = 2'd1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("held_busy", 64'(bus.req_ready), 64'd0);
            if (k <= 2) chk("held_addr", 64'(bus.mem_addr), 64'(1 + k));
            chk("held_resp", 64'(bus.resp_valid), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("held_rdata", bus.resp_rdata, ref_line(1));
        last_fill = ref_line(1);
        @(negedge clk);
        chk("held_ready_after", 64'(bus.req_ready),  64'd1);
        chk("held_no_resp",     64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("held2_addr0", 64'(bus.mem_addr),  64'd2);
        chk("held2_busy",  64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("held2_addr1", 64'(bus.mem_addr), 64'd3);
        @(negedge clk);
        chk("held2_gap", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        chk("held2_resp",  64'(bus.resp_valid), 64'd1);
        chk("held2_rdata", bus.resp_rdata,      ref_line(1));
        @(negedge clk);
        chk("held_resp_count", 64'(resp_cnt - rc0), 64'd2);

        // reset during cycle 1 of a writeback to line 1
        old2 = ram[2];
        old3 = ram[3];
        wd   = {$urandom, $urandom};
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_write     = 1'b1;
        bus.req_line_addr = 2'd1;
        bus.req_wdata     = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        rc0 = resp_cnt;
        chk("arst_we",    64'(bus.mem_we),     64'd0);
        chk("arst_ready", 64'(bus.req_ready),  64'd1);
        chk("arst_rdata", bus.resp_rdata,      64'd0);
        chk("arst_addr",  64'(bus.mem_addr),   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_resp", 64'(bus.resp_valid), 64'd0);
            chk("arst_idle",    64'(bus.req_ready),  64'd1);
        end
        chk("arst_resp_count", 64'(resp_cnt - rc0), 64'd0);
        chk("arst_ram3",       64'(ram[3]),         64'(old3));
        chk("arst_ram2_legal", 64'((ram[2] === old2) || (ram[2] === wd[31:0])), 64'd1);
        ref_mem[2] = ram[2];
        last_fill  = '0;
        exp_din    = '0;

        // back-to-back fill then writeback of line 0; top-line fill
        xfer(1'b0, 0, '0);
        xfer(1'b1, 0, {$urandom, $urandom});
        xfer(1'b0, 3, '0);

        // randomized transfers against the reference RAM contents
        for (int n = 0; n < 24; n++) begin
            xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), {$urandom, $urandom});
        end

        // final RAM image
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("ram_final", 64'(ram[i]), 64'(ref_mem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
